// File: rtl/pe_row_conv.sv
// -----------------------------------------------------------------------------
// pe_row_conv -- serial row-stationary processing element
//
// Holds one filter row (FILTER_SIZE taps) and one ifmap row (IFMAP_W pixels)
// in local scratchpads. For each of OUT_W = IFMAP_W-FILTER_SIZE+1 outputs it
// takes one psum from the PE below, accumulates FILTER_SIZE products at one
// MAC per cycle, and offers the result to the PE above. The filter stays
// resident across ifmap rows until a new filter is loaded.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   filt_valid/ready/data        filter tap stream, tap 0 first
//   ifmap_valid/ready/data       ifmap pixel stream, pixel 0 first
//   psum_in_valid/ready/data     psum from the PE below
//   psum_out_valid/ready/data    psum to the PE above
//   filt_loaded                  filter scratchpad holds a complete filter
//   busy                         high in every state except IDLE
//   row_done                     one-cycle pulse after the last psum of a row
//
// Build option:
//   PE_SAT_EN  when defined, each MAC addition saturates to the PSUM_W signed
//              range instead of wrapping.
// -----------------------------------------------------------------------------
module pe_row_conv #(
   parameter int DATA_W      = 16,
   parameter int PSUM_W      = 32,
   parameter int FILTER_SIZE = 3,
   parameter int IFMAP_W     = 7
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     filt_valid,
   output logic                     filt_ready,
   input  logic signed [DATA_W-1:0] filt_data,

   input  logic                     ifmap_valid,
   output logic                     ifmap_ready,
   input  logic signed [DATA_W-1:0] ifmap_data,

   input  logic                     psum_in_valid,
   output logic                     psum_in_ready,
   input  logic signed [PSUM_W-1:0] psum_in_data,

   output logic                     psum_out_valid,
   input  logic                     psum_out_ready,
   output logic signed [PSUM_W-1:0] psum_out_data,

   output logic                     filt_loaded,
   output logic                     busy,
   output logic                     row_done
);

   localparam int OUT_W = IFMAP_W - FILTER_SIZE + 1;
   localparam int F_CW  = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
   localparam int I_CW  = (IFMAP_W > 1)     ? $clog2(IFMAP_W)     : 1;
   localparam int O_CW  = (OUT_W > 1)       ? $clog2(OUT_W)       : 1;

   localparam logic [F_CW-1:0] F_LAST = F_CW'(FILTER_SIZE - 1);
   localparam logic [I_CW-1:0] I_LAST = I_CW'(IFMAP_W - 1);
   localparam logic [O_CW-1:0] O_LAST = O_CW'(OUT_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_F,
      S_LOAD_I,
      S_ACC_LD,
      S_MAC,
      S_OUT
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                     state_q;
   logic [F_CW-1:0]            f_cnt_q;
   logic [F_CW-1:0]            k_q;
   logic [I_CW-1:0]            i_cnt_q;
   logic [O_CW-1:0]            o_cnt_q;
   logic signed [PSUM_W-1:0]   acc_q;
   logic                       filt_loaded_q;
   logic                       row_done_q;
   logic signed [DATA_W-1:0]   filt_spad_q  [FILTER_SIZE];
   logic signed [DATA_W-1:0]   ifmap_spad_q [IFMAP_W];

   // ---------------------------------------------------------------------------
   // MAC datapath
   // ---------------------------------------------------------------------------
   logic [I_CW-1:0]            pix_idx;
   logic signed [DATA_W-1:0]   tap_sel;
   logic signed [DATA_W-1:0]   pix_sel;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [PSUM_W-1:0]   prod_ext;
   logic signed [PSUM_W-1:0]   acc_d;

   // Output o uses pixels o .. o+FILTER_SIZE-1; the sum never exceeds IFMAP_W-1.
   assign pix_idx = I_CW'(o_cnt_q) + I_CW'(k_q);
   assign tap_sel = filt_spad_q[k_q];
   assign pix_sel = ifmap_spad_q[pix_idx];

   // Operands widened as signed first so the product is the full 2*DATA_W value.
   assign prod     = (2*DATA_W)'(tap_sel) * (2*DATA_W)'(pix_sel);
   assign prod_ext = PSUM_W'(prod);

`ifdef PE_SAT_EN
   logic signed [PSUM_W-1:0] sum_raw;
   logic                     sum_ovf;

   assign sum_raw = acc_q + prod_ext;
   // Overflow only when both operands share a sign and the result flips it.
   assign sum_ovf = (acc_q[PSUM_W-1] == prod_ext[PSUM_W-1]) &&
                    (sum_raw[PSUM_W-1] != acc_q[PSUM_W-1]);

   always_comb begin
      // NOTE: assign a default before any conditional update so no latch is inferred.
      acc_d = sum_raw;
      if (sum_ovf) begin
         acc_d = acc_q[PSUM_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                 : {1'b0, {(PSUM_W-1){1'b1}}};
      end
   end
`else
   assign acc_d = acc_q + prod_ext;
`endif

   // ---------------------------------------------------------------------------
   // Handshake and status outputs: decoded from the registered state only
   // ---------------------------------------------------------------------------
   assign filt_ready     = (state_q == S_LOAD_F);
   assign ifmap_ready    = (state_q == S_LOAD_I);
   assign psum_in_ready  = (state_q == S_ACC_LD);
   assign psum_out_valid = (state_q == S_OUT);
   assign psum_out_data  = acc_q;
   assign busy           = (state_q != S_IDLE);
   assign filt_loaded    = filt_loaded_q;
   assign row_done       = row_done_q;

   // ---------------------------------------------------------------------------
   // Control FSM and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         f_cnt_q       <= '0;
         k_q           <= '0;
         i_cnt_q       <= '0;
         o_cnt_q       <= '0;
         acc_q         <= '0;
         filt_loaded_q <= 1'b0;
         row_done_q    <= 1'b0;
         // NOTE: the scratchpads are small register files, so they are cleared
         // on reset like any other state; a stale filter can never be reused.
         for (int i = 0; i < FILTER_SIZE; i++) filt_spad_q[i] <= '0;
         for (int i = 0; i < IFMAP_W; i++)     ifmap_spad_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // samples the pre-edge values of the others.
         row_done_q <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               // The filter has priority; a stray ifmap without a filter is ignored.
               if (filt_valid) begin
                  f_cnt_q       <= '0;
                  filt_loaded_q <= 1'b0;
                  state_q       <= S_LOAD_F;
               end else if (ifmap_valid && filt_loaded_q) begin
                  i_cnt_q <= '0;
                  state_q <= S_LOAD_I;
               end
            end

            S_LOAD_F: begin
               if (filt_valid && filt_ready) begin
                  filt_spad_q[f_cnt_q] <= filt_data;
                  if (f_cnt_q == F_LAST) begin
                     filt_loaded_q <= 1'b1;
                     i_cnt_q       <= '0;
                     state_q       <= S_LOAD_I;
                  end else begin
                     f_cnt_q <= f_cnt_q + F_CW'(1);
                  end
               end
            end

            S_LOAD_I: begin
               if (ifmap_valid && ifmap_ready) begin
                  ifmap_spad_q[i_cnt_q] <= ifmap_data;
                  if (i_cnt_q == I_LAST) begin
                     o_cnt_q <= '0;
                     state_q <= S_ACC_LD;
                  end else begin
                     i_cnt_q <= i_cnt_q + I_CW'(1);
                  end
               end
            end

            S_ACC_LD: begin
               if (psum_in_valid && psum_in_ready) begin
                  acc_q   <= psum_in_data;
                  k_q     <= '0;
                  state_q <= S_MAC;
               end
            end

            S_MAC: begin
               acc_q <= acc_d;
               if (k_q == F_LAST) begin
                  state_q <= S_OUT;
               end else begin
                  k_q <= k_q + F_CW'(1);
               end
            end

            S_OUT: begin
               // acc_q is untouched here, so the output holds while stalled.
               if (psum_out_valid && psum_out_ready) begin
                  if (o_cnt_q == O_LAST) begin
                     row_done_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     o_cnt_q <= o_cnt_q + O_CW'(1);
                     state_q <= S_ACC_LD;
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
